ahb2apb2_bridge: RTL and testbench

AHB2APB2_BRIDGE -- requirements
Module: ahb2apb2_bridge

---
 rtl/ahb2apb2_bridge_if.sv | 47 ++++
 rtl/ahb2apb2_bridge.sv | 184 ++++++++++++++++++
 tb/tb_ahb2apb2_bridge.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb2apb2_bridge_if.sv
// Bus bundles for the AHB-Lite to APB bridge: an AHB-Lite bundle and an APB bundle,
// each with master and slave views.

interface ahb_lite_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [3:0]  hprot;
  logic        hwrite;
  logic        hready;
  logic [31:0] hwdata;
  logic        hreadyout;
  logic [1:0]  hresp;
  logic [31:0] hrdata;

  modport master (
    output hsel, haddr, htrans, hsize, hprot, hwrite, hready, hwdata,
    input  hreadyout, hresp, hrdata
  );
  modport slave (
    input  hsel, haddr, htrans, hsize, hprot, hwrite, hready, hwdata,
    output hreadyout, hresp, hrdata
  );
endinterface

interface apb_if;
  logic        psel;
  logic        penable;
  logic [31:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, paddr, pwrite, pwdata, pstrb, pprot,
    input  prdata, pready, pslverr
  );
  modport slave (
    input  psel, penable, paddr, pwrite, pwdata, pstrb, pprot,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/ahb2apb2_bridge.sv
// AHB-Lite slave to APB master bridge, single clock domain, all outputs registered.
// Optional ACCESS-phase timeout enabled by defining APB2_BRIDGE_TIMEOUT_EN.

module ahb2apb2_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic      apb2_root_clk,
  input  logic      apb2_root_rst,
  ahb_lite_if.slave ahb,
  apb_if.master     apb
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SAMPLE = 3'd1,
    SETUP  = 3'd2,
    ACCESS = 3'd3,
    DONE   = 3'd4,
    ERR1   = 3'd5,
    ERR2   = 3'd6
  } state_t;

  state_t      state_r;
  logic [31:0] addr_r;
  logic        write_r;
  logic [2:0]  size_r;
  logic [1:0]  prot_r;
  logic        hreadyout_r;
  logic [1:0]  hresp_r;
  logic [31:0] hrdata_r;
  logic        psel_r;
  logic        penable_r;
  logic [31:0] paddr_r;
  logic        pwrite_r;
  logic [31:0] pwdata_r;
  logic [3:0]  pstrb_r;
  logic [2:0]  pprot_r;
  logic        accept_s;
  logic        unused_s;

`ifdef APB2_BRIDGE_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 32'd1);
  logic [15:0] cnt_r;
`else
  logic [31:0] unused_timeout_s;
  assign unused_timeout_s = 32'(TIMEOUT_CYCLES);
`endif

  function automatic logic [3:0] strobe_f(input logic write, input logic [2:0] size,
                                           input logic [1:0] addr_lo);
    logic [3:0] strb;
    strb = 4'b0000;
    if (write) begin
      case (size)
        3'd0:    strb = 4'b0001 << addr_lo;
        3'd1:    strb = 4'b0011 << {addr_lo[1], 1'b0};
        3'd2:    strb = 4'b1111;
        default: strb = 4'b0000;
      endcase
    end else begin
      strb = 4'b0000;
    end
    return strb;
  endfunction

  assign accept_s = ahb.hsel & ahb.hready & ahb.htrans[1] &
                    ((state_r == IDLE) | (state_r == DONE) | (state_r == ERR2));
  assign unused_s = &{1'b0, ahb.htrans[0], ahb.hprot[3:2]};

  // Transfer sequencer: AHB acceptance, APB setup/access, response generation
  always_ff @(posedge apb2_root_clk or posedge apb2_root_rst) begin
    if (apb2_root_rst) begin
      state_r     <= IDLE;
      addr_r      <= 32'h0000_0000;
      write_r     <= 1'b0;
      size_r      <= 3'd0;
      prot_r      <= 2'b00;
      hreadyout_r <= 1'b1;
      hresp_r     <= 2'b00;
      hrdata_r    <= 32'h0000_0000;
      psel_r      <= 1'b0;
      penable_r   <= 1'b0;
      paddr_r     <= 32'h0000_0000;
      pwrite_r    <= 1'b0;
      pwdata_r    <= 32'h0000_0000;
      pstrb_r     <= 4'b0000;
      pprot_r     <= 3'b000;
`ifdef APB2_BRIDGE_TIMEOUT_EN
      cnt_r       <= 16'd0;
`endif
    end else begin
      case (state_r)
        IDLE, DONE, ERR2: begin
          hresp_r <= 2'b00;
          if (accept_s) begin
            state_r     <= SAMPLE;
            hreadyout_r <= 1'b0;
            addr_r      <= ahb.haddr;
            write_r     <= ahb.hwrite;
            size_r      <= ahb.hsize;
            prot_r      <= ahb.hprot[1:0];
          end else begin
            state_r     <= IDLE;
            hreadyout_r <= 1'b1;
          end
        end
        SAMPLE: begin
          // hwdata belongs to the data phase, so it is valid only now
          if (write_r) begin
            pwdata_r <= ahb.hwdata;
          end
          if (size_r >= 3'd3) begin
            state_r <= ERR1;
            hresp_r <= 2'b01;
          end else begin
            state_r   <= SETUP;
            psel_r    <= 1'b1;
            penable_r <= 1'b0;
            paddr_r   <= addr_r;
            pwrite_r  <= write_r;
            pstrb_r   <= strobe_f(write_r, size_r, addr_r[1:0]);
            pprot_r   <= {~prot_r[0], 1'b0, prot_r[1]};
          end
        end
        SETUP: begin
          state_r   <= ACCESS;
          penable_r <= 1'b1;
`ifdef APB2_BRIDGE_TIMEOUT_EN
          cnt_r     <= 16'd0;
`endif
        end
        ACCESS: begin
          if (apb.pready) begin
            psel_r    <= 1'b0;
            penable_r <= 1'b0;
            if (apb.pslverr) begin
              state_r <= ERR1;
              hresp_r <= 2'b01;
            end else begin
              state_r     <= DONE;
              hreadyout_r <= 1'b1;
              hresp_r     <= 2'b00;
              if (!write_r) begin
                hrdata_r <= apb.prdata;
              end
            end
`ifdef APB2_BRIDGE_TIMEOUT_EN
          end else if (cnt_r == TIMEOUT_LAST) begin
            psel_r    <= 1'b0;
            penable_r <= 1'b0;
            state_r   <= ERR1;
            hresp_r   <= 2'b01;
          end else begin
            cnt_r <= cnt_r + 16'd1;
`endif
          end
        end
        ERR1: begin
          state_r     <= ERR2;
          hreadyout_r <= 1'b1;
        end
        default: begin
          state_r     <= IDLE;
          hreadyout_r <= 1'b1;
          hresp_r     <= 2'b00;
          psel_r      <= 1'b0;
          penable_r   <= 1'b0;
        end
      endcase
    end
  end

  assign ahb.hreadyout = hreadyout_r;
  assign ahb.hresp     = hresp_r;
  assign ahb.hrdata    = hrdata_r;
  assign apb.psel      = psel_r;
  assign apb.penable   = penable_r;
  assign apb.paddr     = paddr_r;
  assign apb.pwrite    = pwrite_r;
  assign apb.pwdata    = pwdata_r;
  assign apb.pstrb     = pstrb_r;
  assign apb.pprot     = pprot_r;

endmodule

// File: tb/tb_ahb2apb2_bridge.sv
// Self-checking bench for ahb2apb2_bridge: vector table plus scoreboard queues,
// with hand sequences for no-op, timeout and mid-transfer reset.
`timescale 1ns/1ps

module tb_ahb2apb2_bridge;
  localparam int unsigned TO_CYCLES = 4;

  logic clk = 1'b0;
  logic rst;
  logic hready_block;

  always #5 clk = ~clk;

  ahb_lite_if ahb_bus ();
  apb_if      apb_bus ();

  assign ahb_bus.hready = hready_block ? 1'b0 : ahb_bus.hreadyout;

  ahb2apb2_bridge #(.TIMEOUT_CYCLES(TO_CYCLES)) dut (
    .apb2_root_clk (clk),
    .apb2_root_rst (rst),
    .ahb           (ahb_bus),
    .apb           (apb_bus)
  );

  typedef struct {
    logic        hwrite;
    logic [31:0] haddr;
    logic [2:0]  hsize;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic [31:0] prdata;
    logic        pslverr;
    int          waits;
    logic        b2b;
    logic [3:0]  exp_pstrb;
    logic [2:0]  exp_pprot;
  } vec_t;

  typedef struct {
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
  } apb_exp_t;

  typedef struct {
    logic [1:0]  hresp;
    logic [31:0] hrdata;
  } rsp_exp_t;

  apb_exp_t    apb_q[$];
  rsp_exp_t    rsp_q[$];
  vec_t        vecs[10];
  int          checks;
  int          failures;
  logic [31:0] hrdata_model;
  logic [31:0] pwdata_model;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    ahb_bus.hsel   = 1'b0;
    ahb_bus.htrans = 2'b00;
    ahb_bus.haddr  = 32'h0000_0000;
    ahb_bus.hwrite = 1'b0;
    ahb_bus.hsize  = 3'd0;
    ahb_bus.hprot  = 4'b0000;
  endtask

  task automatic drive_addr(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                            input logic [3:0] prot);
    ahb_bus.hsel   = 1'b1;
    ahb_bus.htrans = 2'b10;
    ahb_bus.haddr  = addr;
    ahb_bus.hwrite = wr;
    ahb_bus.hsize  = size;
    ahb_bus.hprot  = prot;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_hreadyout"}, 32'(ahb_bus.hreadyout), 32'd1);
    check({tag, "_hresp"},     32'(ahb_bus.hresp),     32'd0);
    check({tag, "_hrdata"},    ahb_bus.hrdata,         32'd0);
    check({tag, "_psel"},      32'(apb_bus.psel),      32'd0);
    check({tag, "_penable"},   32'(apb_bus.penable),   32'd0);
    check({tag, "_paddr"},     apb_bus.paddr,          32'd0);
    check({tag, "_pwrite"},    32'(apb_bus.pwrite),    32'd0);
    check({tag, "_pwdata"},    apb_bus.pwdata,         32'd0);
    check({tag, "_pstrb"},     32'(apb_bus.pstrb),     32'd0);
    check({tag, "_pprot"},     32'(apb_bus.pprot),     32'd0);
  endtask

  task automatic check_apb(input string tag, input apb_exp_t ae);
    check({tag, "_paddr"},  apb_bus.paddr,        ae.paddr);
    check({tag, "_pwrite"}, 32'(apb_bus.pwrite),  32'(ae.pwrite));
    check({tag, "_pwdata"}, apb_bus.pwdata,       ae.pwdata);
    check({tag, "_pstrb"},  32'(apb_bus.pstrb),   32'(ae.pstrb));
    check({tag, "_pprot"},  32'(apb_bus.pprot),   32'(ae.pprot));
  endtask

  // One complete transfer; entered and left at a negedge, address driven on entry
  task automatic xfer(input vec_t v);
    apb_exp_t ae;
    rsp_exp_t re;
    drive_addr(v.hwrite, v.haddr, v.hsize, v.hprot);
    if (v.hwrite) pwdata_model = v.hwdata;
    if (v.hsize < 3'd3) begin
      ae = '{v.haddr, v.hwrite, pwdata_model, v.exp_pstrb, v.exp_pprot};
      apb_q.push_back(ae);
    end
    if (!v.hwrite && !v.pslverr && v.hsize < 3'd3) hrdata_model = v.prdata;
    re.hresp  = (v.pslverr || v.hsize >= 3'd3) ? 2'b01 : 2'b00;
    re.hrdata = hrdata_model;
    rsp_q.push_back(re);
    check("t0_hreadyout", 32'(ahb_bus.hreadyout), 32'd1);

    @(negedge clk);
    check("t1_hreadyout", 32'(ahb_bus.hreadyout), 32'd0);
    check("t1_psel", 32'(apb_bus.psel), 32'd0);
    drive_idle();
    ahb_bus.hwdata = v.hwdata;

    if (v.hsize >= 3'd3) begin
      @(negedge clk);
      check("sz_err1_hreadyout", 32'(ahb_bus.hreadyout), 32'd0);
      check("sz_err1_hresp", 32'(ahb_bus.hresp), 32'd1);
      check("sz_err1_psel", 32'(apb_bus.psel), 32'd0);
      @(negedge clk);
    end else begin
      @(negedge clk);
      if (apb_q.size() == 0) begin
        check("apb_q_empty", 32'd0, 32'd1);
        return;
      end
      ae = apb_q.pop_front();
      check("setup_psel", 32'(apb_bus.psel), 32'd1);
      check("setup_penable", 32'(apb_bus.penable), 32'd0);
      check_apb("setup", ae);
      // Responses driven during SETUP must be ignored
      apb_bus.pready  = 1'b1;
      apb_bus.pslverr = 1'b1;
      apb_bus.prdata  = 32'hDEAD_0000;
      for (int w = 0; w <= v.waits; w++) begin
        @(negedge clk);
        check("access_psel", 32'(apb_bus.psel), 32'd1);
        check("access_penable", 32'(apb_bus.penable), 32'd1);
        check("access_hreadyout", 32'(ahb_bus.hreadyout), 32'd0);
        check_apb("access", ae);
        apb_bus.pready  = (w == v.waits);
        apb_bus.pslverr = v.pslverr;
        apb_bus.prdata  = (w == v.waits) ? v.prdata : $urandom();
      end
      @(negedge clk);
      check("post_psel", 32'(apb_bus.psel), 32'd0);
      check("post_penable", 32'(apb_bus.penable), 32'd0);
      apb_bus.pready  = 1'b0;
      apb_bus.pslverr = 1'b0;
      if (v.pslverr) begin
        check("err1_hreadyout", 32'(ahb_bus.hreadyout), 32'd0);
        check("err1_hresp", 32'(ahb_bus.hresp), 32'd1);
        @(negedge clk);
      end
    end

    if (rsp_q.size() == 0) begin
      check("rsp_q_empty", 32'd0, 32'd1);
      return;
    end
    re = rsp_q.pop_front();
    check("rsp_hreadyout", 32'(ahb_bus.hreadyout), 32'd1);
    check("rsp_hresp", 32'(ahb_bus.hresp), 32'(re.hresp));
    check("rsp_hrdata", ahb_bus.hrdata, re.hrdata);
  endtask

  initial begin
    vec_t vr;
    checks       = 0;
    failures     = 0;
    hrdata_model = 32'h0000_0000;
    pwdata_model = 32'h0000_0000;
    //           wr    haddr         sz    hprot    hwdata        prdata        err  w  b2b  pstrb    pprot
    vecs[0] = '{1'b1, 32'h4002_1004, 3'd2, 4'b0011, 32'hA5A5_1234, 32'h0,        1'b0, 0, 1'b0, 4'b1111, 3'b001};
    vecs[1] = '{1'b1, 32'h4002_0003, 3'd0, 4'b0000, 32'h1122_3344, 32'h0,        1'b0, 0, 1'b0, 4'b1000, 3'b100};
    vecs[2] = '{1'b0, 32'h4002_0002, 3'd1, 4'b0010, 32'h0,         32'h0000_BEEF, 1'b0, 0, 1'b1, 4'b0000, 3'b101};
    vecs[3] = '{1'b0, 32'h4003_0010, 3'd2, 4'b0001, 32'h0,         32'hCAFE_F00D, 1'b0, 5, 1'b0, 4'b0000, 3'b000};
    vecs[4] = '{1'b1, 32'h4000_0008, 3'd2, 4'b0011, 32'h0BAD_C0DE, 32'h0,        1'b1, 0, 1'b0, 4'b1111, 3'b001};
    vecs[5] = '{1'b1, 32'h4000_0006, 3'd1, 4'b0000, 32'h5566_7788, 32'h0,        1'b0, 1, 1'b1, 4'b1100, 3'b100};
    vecs[6] = '{1'b1, 32'h4000_0001, 3'd0, 4'b0010, 32'h99AA_BBCC, 32'h0,        1'b0, 0, 1'b1, 4'b0010, 3'b101};
    vecs[7] = '{1'b0, 32'h4000_0000, 3'd3, 4'b0000, 32'h0,         32'h0,        1'b0, 0, 1'b0, 4'b0000, 3'b000};
    vecs[8] = '{1'b0, 32'h4000_0010, 3'd2, 4'b0001, 32'h0,         32'h7777_8888, 1'b1, 2, 1'b1, 4'b0000, 3'b000};
    vecs[9] = '{1'b1, 32'h4000_0014, 3'd1, 4'b0011, 32'h1234_5678, 32'h0,        1'b0, 0, 1'b0, 4'b0011, 3'b001};

    rst             = 1'b1;
    hready_block    = 1'b0;
    drive_idle();
    ahb_bus.hwdata  = 32'h0000_0000;
    apb_bus.pready  = 1'b0;
    apb_bus.pslverr = 1'b0;
    apb_bus.prdata  = 32'h0000_0000;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      if (!vecs[i].b2b) begin
        drive_idle();
        @(negedge clk);
        check("gap_hreadyout", 32'(ahb_bus.hreadyout), 32'd1);
      end
      xfer(vecs[i]);
    end
    drive_idle();
    @(negedge clk);
    check("idle_after_table", 32'(ahb_bus.hreadyout), 32'd1);

    // BUSY and hready-low NONSEQ must not start a transfer
    ahb_bus.hsel   = 1'b1;
    ahb_bus.htrans = 2'b01;
    ahb_bus.haddr  = 32'h4004_0000;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("busy_hreadyout", 32'(ahb_bus.hreadyout), 32'd1);
      check("busy_hresp", 32'(ahb_bus.hresp), 32'd0);
      check("busy_psel", 32'(apb_bus.psel), 32'd0);
    end
    ahb_bus.htrans = 2'b10;
    hready_block   = 1'b1;
    @(negedge clk);
    drive_idle();
    hready_block = 1'b0;
    check("noaccept_hreadyout", 32'(ahb_bus.hreadyout), 32'd1);
    @(negedge clk);
    check("noaccept_psel", 32'(apb_bus.psel), 32'd0);

    // Slave that never answers
    drive_addr(1'b0, 32'h4006_0000, 3'd2, 4'b0000);
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    check("to_setup_psel", 32'(apb_bus.psel), 32'd1);
    apb_bus.pready = 1'b0;
`ifdef APB2_BRIDGE_TIMEOUT_EN
    for (int w = 0; w < int'(TO_CYCLES); w++) begin
      @(negedge clk);
      check("to_access_penable", 32'(apb_bus.penable), 32'd1);
      check("to_access_hreadyout", 32'(ahb_bus.hreadyout), 32'd0);
    end
    @(negedge clk);
    check("to_psel_drop", 32'(apb_bus.psel), 32'd0);
    check("to_err1_hresp", 32'(ahb_bus.hresp), 32'd1);
    check("to_err1_hreadyout", 32'(ahb_bus.hreadyout), 32'd0);
    @(negedge clk);
    check("to_err2_hresp", 32'(ahb_bus.hresp), 32'd1);
    check("to_err2_hreadyout", 32'(ahb_bus.hreadyout), 32'd1);
`else
    for (int w = 0; w < 20; w++) begin
      @(negedge clk);
      check("nto_hreadyout", 32'(ahb_bus.hreadyout), 32'd0);
      check("nto_penable", 32'(apb_bus.penable), 32'd1);
    end
    apb_bus.pready = 1'b1;
    apb_bus.prdata = 32'h1357_9BDF;
    @(negedge clk);
    apb_bus.pready = 1'b0;
    hrdata_model   = 32'h1357_9BDF;
    check("nto_done_hreadyout", 32'(ahb_bus.hreadyout), 32'd1);
    check("nto_done_hrdata", ahb_bus.hrdata, hrdata_model);
`endif
    @(negedge clk);

    // Reset pulse in the middle of ACCESS
    drive_addr(1'b1, 32'h4005_0000, 3'd2, 4'b0011);
    @(negedge clk);
    drive_idle();
    ahb_bus.hwdata = 32'hFEED_FACE;
    @(negedge clk);
    @(negedge clk);
    check("rstmid_penable", 32'(apb_bus.penable), 32'd1);
    #2 rst = 1'b1;
    #1 check_reset_vals("rstmid");
    @(negedge clk);
    rst          = 1'b0;
    hrdata_model = 32'h0000_0000;
    pwdata_model = 32'h0000_0000;
    vr = '{1'b0, 32'h4007_0004, 3'd2, 4'b0011, 32'h0, 32'h2468_ACE0, 1'b0, 0, 1'b1, 4'b0000, 3'b001};
    xfer(vr);
    drive_idle();
    @(negedge clk);

    check("sb_apb_drained", 32'(apb_q.size()), 32'd0);
    check("sb_rsp_drained", 32'(rsp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
